// File: rtl/vga_timing_pkg.sv
// Shared VGA timing package: default 640x480@60 timing constants,
// 12-bit RGB colour constants used by the display blocks, and a small
// helper for sizing counters.
package vga_timing_pkg;

    // Default horizontal timing, in pixels.
    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_VIS_START = 144;
    localparam int DEF_H_VIS_END   = 783;

    // Default vertical timing, in lines.
    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_VIS_START = 35;
    localparam int DEF_V_VIS_END   = 514;

    // Default pixel clock divider (100 MHz system clock -> 25 MHz pixels).
    localparam int DEF_PIX_DIV     = 4;

    // Default number of frames per game-logic update.
    localparam int DEF_TICK_FRAMES = 2;

    // Width of the screen-position counters.
    localparam int POS_W = 10;

    // 12-bit colours, 4 bits per channel, packed as {R, G, B}.
    localparam logic [11:0] COLOR_BLACK   = 12'h000;
    localparam logic [11:0] COLOR_WHITE   = 12'hFFF;
    localparam logic [11:0] COLOR_RED     = 12'hF00;
    localparam logic [11:0] COLOR_GREEN   = 12'h0F0;
    localparam logic [11:0] COLOR_BLUE    = 12'h00F;
    localparam logic [11:0] COLOR_YELLOW  = 12'hFF0;
    localparam logic [11:0] COLOR_CYAN    = 12'h0FF;
    localparam logic [11:0] COLOR_MAGENTA = 12'hF0F;
    localparam logic [11:0] COLOR_GREY    = 12'h888;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_enable_div.sv
// Clock-enable divider: produces a one-cycle strobe every DIV clk cycles.
// The strobe is high while the internal counter sits at DIV-1, so after
// reset release the first strobe appears in the DIV-th cycle. With DIV==1
// the strobe is constantly high.
module clk_enable_div
    import vga_timing_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic en
);

    generate
        if (DIV <= 1) begin : g_passthru
            // No division: every clk cycle is an enable cycle.
            logic unused_inputs;
            assign unused_inputs = clk ^ rst;
            assign en = 1'b1;
        end else begin : g_div
            localparam int            CW   = cnt_width(DIV);
            localparam logic [CW-1:0] LAST = CW'(DIV - 1);

            logic [CW-1:0] div_cnt;

            // Free-running modulo-DIV counter, cleared asynchronously by rst.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    div_cnt <= '0;
                end else if (div_cnt == LAST) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + CW'(1);
                end
            end

            // div_cnt is zero in reset and LAST is non-zero, so en is low in reset.
            assign en = (div_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/display_timing_gen.sv
// VGA display timing generator.
// Divides clk down to the pixel rate, runs the horizontal/vertical screen
// counters, decodes active-low syncs and the visible-window flag straight
// from the counters, and emits a one-clk frame_tick at the start of
// vertical blanking.
// Optional feature: define GAME_TICK_EN to add a frame counter that raises
// game_tick on every TICK_FRAMES-th frame_tick; otherwise game_tick is 0.
module display_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV     = DEF_PIX_DIV,
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int H_VIS_START = DEF_H_VIS_START,
    parameter int H_VIS_END   = DEF_H_VIS_END,
    parameter int V_VIS_START = DEF_V_VIS_START,
    parameter int V_VIS_END   = DEF_V_VIS_END,
    parameter int TICK_FRAMES = DEF_TICK_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick,
    output logic       game_tick
);

    // Timing constants narrowed to counter width for clean comparisons.
    localparam logic [POS_W-1:0] H_LAST    = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST    = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_SYNC_C  = POS_W'(H_SYNC);
    localparam logic [POS_W-1:0] V_SYNC_C  = POS_W'(V_SYNC);
    localparam logic [POS_W-1:0] H_VS_C    = POS_W'(H_VIS_START);
    localparam logic [POS_W-1:0] H_VE_C    = POS_W'(H_VIS_END);
    localparam logic [POS_W-1:0] V_VS_C    = POS_W'(V_VIS_START);
    localparam logic [POS_W-1:0] V_VE_C    = POS_W'(V_VIS_END);

    logic h_last;
    logic v_last;
    logic frame_evt;
    logic h_vis;
    logic v_vis;

    clk_enable_div #(
        .DIV (PIX_DIV)
    ) u_pix_div (
        .clk (clk),
        .rst (rst),
        .en  (pix_en)
    );

    assign h_last = (hCount == H_LAST);
    assign v_last = (vCount == V_LAST);

    // The pixel edge that moves vCount from the last visible line into blanking.
    assign frame_evt = pix_en & h_last & (vCount == V_VE_C);

    // Screen position counters: hCount advances per pixel, vCount per line wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCount <= '0;
            vCount <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                hCount <= '0;
                vCount <= v_last ? '0 : vCount + POS_W'(1);
            end else begin
                hCount <= hCount + POS_W'(1);
            end
        end
    end

    // Zero-latency decode from the registered counters; forced low during rst.
    assign h_vis  = (hCount >= H_VS_C) && (hCount <= H_VE_C);
    assign v_vis  = (vCount >= V_VS_C) && (vCount <= V_VE_C);
    assign hSync  = ~rst & (hCount >= H_SYNC_C);
    assign vSync  = ~rst & (vCount >= V_SYNC_C);
    assign bright = ~rst & h_vis & v_vis;

    // One-clk frame pulse, registered so it coincides with vCount reading V_VIS_END+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_evt;
        end
    end

`ifdef GAME_TICK_EN
    localparam int            FW     = cnt_width(TICK_FRAMES);
    localparam logic [FW-1:0] F_LAST = FW'(TICK_FRAMES - 1);

    logic [FW-1:0] frame_cnt;

    // Count frames modulo TICK_FRAMES; game_tick rides on the wrapping frame_tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            game_tick <= 1'b0;
        end else begin
            game_tick <= frame_evt & (frame_cnt == F_LAST);
            if (frame_evt) begin
                frame_cnt <= (frame_cnt == F_LAST) ? '0 : frame_cnt + FW'(1);
            end
        end
    end
`else
    localparam int UNUSED_TICK_FRAMES = TICK_FRAMES;
    assign game_tick = 1'b0;
`endif

endmodule
